// File: rtl/am_gain_div.sv
// am_gain_div: amplitude scaler for the DDS wave path.
// Sample is divided by a key-selected divisor (1..MAX_DIV) in a sequential
// restoring divider. Up/down keys are synchronised and debounced in the clk
// domain. A two-digit active-low 7-segment readout shows the divisor.
// Optional build macro: AM_DIV1_BYPASS_EN -- when defined, a divisor snapshot
// of 1 skips the divider and returns the sample one cycle after acceptance.

// Per-key synchroniser + debouncer; emits a one-cycle pulse on a debounced press.
module am_key_deb #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Two-flop synchroniser, then a level must differ for DEB_CYC cycles to commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        r_deb   <= r_sync[1];
        r_cnt   <= '0;
        // only the falling (press) edge is reported; release is silent
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

module am_gain_div #(
  parameter int DW      = 8,
  parameter int MAX_DIV = 15,
  parameter int DEB_CYC = 500000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_up,
  input  logic          key_dn,
  input  logic          in_valid,
  input  logic [DW-1:0] data,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] wave_data,
  output logic [6:0]    div_val,
  output logic [6:0]    seg_tens,
  output logic [6:0]    seg_ones
);
  // compare width must hold both the shifted remainder and the 7-bit divisor
  localparam int CW   = (DW + 1 > 7) ? DW + 1 : 7;
  localparam int CNTW = $clog2(DW + 1);
  localparam logic [6:0] MAXD = 7'(MAX_DIV);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  logic [1:0]      w_keys_n;
  logic [1:0]      w_press;   // [0] up, [1] down
  logic [6:0]      r_div;
  state_t          r_state;
  logic [DW-1:0]   r_quo;
  logic [DW-1:0]   r_rem;
  logic [6:0]      r_dsr;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;
  logic            r_ov;
  logic [DW-1:0]   r_wave;
  logic [CW-1:0]   w_shift;
  logic [CW-1:0]   w_dsr_ext;
  logic            w_ge;
  logic [CW-1:0]   w_diff;

  assign w_keys_n = {key_dn, key_up};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_key
      am_key_deb #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (w_keys_n[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  // Divisor register: wraps at both ends, simultaneous presses cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 7'd1;
    end else begin
      case (w_press)
        2'b01:   r_div <= (r_div >= MAXD) ? 7'd1 : r_div + 7'd1;
        2'b10:   r_div <= (r_div <= 7'd1) ? MAXD : r_div - 7'd1;
        default: r_div <= r_div;
      endcase
    end
  end

  // Active-low {g,f,e,d,c,b,a}; out-of-range values blank the digit.
  function automatic logic [6:0] seg7(input logic [6:0] v);
    case (v)
      7'd0:    seg7 = 7'b1000000;
      7'd1:    seg7 = 7'b1111001;
      7'd2:    seg7 = 7'b0100100;
      7'd3:    seg7 = 7'b0110000;
      7'd4:    seg7 = 7'b0011001;
      7'd5:    seg7 = 7'b0010010;
      7'd6:    seg7 = 7'b0000010;
      7'd7:    seg7 = 7'b1111000;
      7'd8:    seg7 = 7'b0000000;
      7'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign seg_tens = seg7(r_div / 7'd10);
  assign seg_ones = seg7(r_div % 7'd10);
  assign div_val  = r_div;

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  assign w_shift   = CW'({r_rem, r_quo[DW-1]});
  assign w_dsr_ext = CW'(r_dsr);
  assign w_ge      = (w_shift >= w_dsr_ext);
  assign w_diff    = w_ge ? (w_shift - w_dsr_ext) : w_shift;

  // Divider FSM: r_quo starts as the dividend and fills with quotient bits MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dsr   <= 7'd1;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ov    <= 1'b0;
      r_wave  <= '0;
    end else begin
      r_ov <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_quo  <= data;
            r_rem  <= '0;
            r_dsr  <= r_div;
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef AM_DIV1_BYPASS_EN
            // quotient by 1 is the sample itself; r_quo already holds it
            r_state <= (r_div == 7'd1) ? S_DONE : S_DIV;
`else
            r_state <= S_DIV;
`endif
          end
        end
        S_DIV: begin
          r_quo <= {r_quo[DW-2:0], w_ge};
          r_rem <= DW'(w_diff);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(DW - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_wave  <= r_quo;
          r_ov    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_ov;
  assign wave_data = r_wave;
endmodule

// File: tb/tb_am_gain_div.sv
// Bench for am_gain_div: table of samples at a fixed divisor, hand sequences
// for key handling, busy drop, mid-divide key press and reset mid-operation.
// Results are checked by a scoreboard queue holding expected value and cycle.
module tb_am_gain_div;
  localparam int DW      = 8;
  localparam int MAX_DIV = 15;
  localparam int DEB     = 4;
`ifdef AM_DIV1_BYPASS_EN
  localparam int LAT1 = 1;
`else
  localparam int LAT1 = DW + 1;
`endif
  localparam int LAT = DW + 1;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_up = 1'b1;
  logic          key_dn = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          busy, out_valid;
  logic [DW-1:0] wave_data;
  logic [6:0]    div_val, seg_tens, seg_ones;

  typedef struct {
    logic [DW-1:0] q;
    int            due;
  } exp_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] q;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  am_gain_div #(.DW(DW), .MAX_DIV(MAX_DIV), .DEB_CYC(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_up    (key_up),
    .key_dn    (key_dn),
    .in_valid  (in_valid),
    .data      (data),
    .busy      (busy),
    .out_valid (out_valid),
    .wave_data (wave_data),
    .div_val   (div_val),
    .seg_tens  (seg_tens),
    .seg_ones  (seg_ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(wave_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wave_data", 32'(wave_data), 32'(e.q));
        chk("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit up, input bit dn);
    key_up = up ? 1'b0 : 1'b1;
    key_dn = dn ? 1'b0 : 1'b1;
    step(DEB + 6);
    key_up = 1'b1;
    key_dn = 1'b1;
    step(DEB + 6);
  endtask

  // Wait (bounded) for idle, present one sample, record its expected result.
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] q, input int lat);
    int t;
    exp_t e;
    t = 0;
    while (busy && t < 40) begin
      step(1);
      t++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    in_valid = 1'b1;
    data     = d;
    e.q      = q;
    e.due    = cyc + 1 + lat;
    sb.push_back(e);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      step(1);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    tbl[0] = '{d: 8'd200, q: 8'd50};
    tbl[1] = '{d: 8'd255, q: 8'd63};
    tbl[2] = '{d: 8'd0,   q: 8'd0};
    tbl[3] = '{d: 8'd3,   q: 8'd0};
    tbl[4] = '{d: 8'd4,   q: 8'd1};
    tbl[5] = '{d: 8'd17,  q: 8'd4};

    // reset state
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("rst_div_val", 32'(div_val), 32'd1);
    chk("rst_seg_tens", 32'(seg_tens), 32'(S0));
    chk("rst_seg_ones", 32'(seg_ones), 32'(S1));
    chk("rst_wave_data", 32'(wave_data), 32'd0);

    // three presses -> divisor 4
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    chk("div_after_3up", 32'(div_val), 32'd4);
    chk("seg_ones_4", 32'(seg_ones), 32'(S4));

    // table vectors at divisor 4
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].q, LAT);
      drain();
    end

    // in_valid while busy is dropped
    send(8'd200, 8'd50, LAT);
    step(2);
    chk("busy_during_div", 32'(busy), 32'd1);
    in_valid = 1'b1;
    data     = 8'd99;
    step(1);
    in_valid = 1'b0;
    drain();
    step(12);

    // key press during divide only affects the next sample
    send(8'd255, 8'd63, LAT);
    press(1'b1, 1'b0);
    drain();
    chk("div_after_mid_press", 32'(div_val), 32'd5);
    send(8'd255, 8'd51, LAT);
    drain();

    // short glitch is filtered
    key_up = 1'b0;
    step(2);
    key_up = 1'b1;
    step(12);
    chk("div_after_glitch", 32'(div_val), 32'd5);

    // both keys together -> no change
    press(1'b1, 1'b1);
    chk("div_after_both", 32'(div_val), 32'd5);

    // climb to the top, then wrap both ways
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0);
    chk("div_at_max", 32'(div_val), 32'd15);
    chk("seg_tens_15", 32'(seg_tens), 32'(S1));
    chk("seg_ones_15", 32'(seg_ones), 32'(S5));
    send(8'd200, 8'd13, LAT);
    drain();
    press(1'b1, 1'b0);
    chk("div_wrap_up", 32'(div_val), 32'd1);
    press(1'b0, 1'b1);
    chk("div_wrap_dn", 32'(div_val), 32'd15);
    chk("seg_ones_15b", 32'(seg_ones), 32'(S5));

    // reset during divide discards the partial result
    send(8'd200, 8'd13, LAT);
    step(2);
    rst_n = 1'b0;
    sb.delete();
    step(2);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step(15);
    chk("midrst_wave_data", 32'(wave_data), 32'd0);
    chk("midrst_div_val", 32'(div_val), 32'd1);

    // divisor 1 returns the sample unchanged
    send(8'd171, 8'd171, LAT1);
    drain();
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1);
  end
endmodule
